// File: rtl/cvxif_instr_pkg.sv
// cvxif_instr_pkg: shared CV-X-IF coprocessor types (result entry layout, result buffer depth)
package cvxif_instr_pkg;
  localparam int unsigned CoproResultDepth = 4;
  localparam int unsigned CoproXlen = 32;
  typedef struct packed {
    logic [CoproXlen-1:0] data;
    logic                 hartid;
    logic                 id;
    logic [4:0]           rd;
    logic                 we;
  } copro_result_t;
endpackage

// File: rtl/copro_result_tx_if.sv
// copro_result_tx_if: CV-X-IF result channel (valid/ready + data, hartid, id, rd, we); master drives, slave accepts
interface copro_result_tx_if #(
  parameter int unsigned XLEN = 32,
  parameter type hartid_t = logic,
  parameter type id_t = logic
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] data;
  hartid_t         hartid;
  id_t             id;
  logic [4:0]      rd;
  logic            we;
  modport master (output valid, data, hartid, id, rd, we, input ready);
  modport slave (input valid, data, hartid, id, rd, we, output ready);
endinterface

// File: rtl/copro_result_fifo.sv
// copro_result_fifo: circular FIFO (push_i/pop_i, wdata_i/rdata_o, full_o/empty_o, cnt_o); push at full accepted only with a pop
module copro_result_fifo
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned DEPTH = CoproResultDepth,
  parameter type entry_t = copro_result_t,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full_o  = cnt_o == CW'(DEPTH);
  assign empty_o = cnt_o == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_o  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt_o <= cnt_o + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end
endmodule

// File: rtl/copro_result_tx.sv
// copro_result_tx: buffers unstallable ALU results and replays them on the CV-X-IF result channel (issue credits, occupancy, sticky overflow)
module copro_result_tx
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DEPTH = CoproResultDepth,
  parameter type hartid_t = logic,
  parameter type id_t = logic,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_fire_i,
  output logic                  issue_ready_o,
  input  logic                  alu_valid_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  hartid_t               alu_hartid_i,
  input  id_t                   alu_id_i,
  input  logic [4:0]            alu_rd_i,
  input  logic                  alu_we_i,
  copro_result_tx_if.master     result,
  output logic [CW-1:0]         occupancy_o,
  output logic                  overflow_o
);
  typedef struct packed {
    logic [XLEN-1:0] data;
    hartid_t         hartid;
    id_t             id;
    logic [4:0]      rd;
    logic            we;
  } entry_t;
  entry_t        wdata, head;
  logic          full, empty, pop;
  logic [CW-1:0] cnt, rsv, rsv_d;
  assign wdata = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i, rd: alu_rd_i, we: alu_we_i};
  assign pop   = result.valid && result.ready;
  copro_result_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (alu_valid_i),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );
  assign issue_ready_o = ({1'b0, cnt} + {1'b0, rsv}) < (CW + 1)'(DEPTH);
  assign rsv_d = (issue_fire_i && !alu_valid_i) ? rsv + CW'(1) :
                 (!issue_fire_i && alu_valid_i && rsv != '0) ? rsv - CW'(1) : rsv;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv        <= '0;
      overflow_o <= 1'b0;
    end else begin
      rsv        <= rsv_d;
      overflow_o <= overflow_o || (alu_valid_i && ((full && !pop) || rsv == '0));
    end
  end
  assign result.valid  = !empty;
  assign result.data   = empty ? '0 : head.data;
  assign result.hartid = empty ? '0 : head.hartid;
  assign result.id     = empty ? '0 : head.id;
  assign result.rd     = empty ? '0 : head.rd;
  assign result.we     = empty ? '0 : head.we;
  assign occupancy_o   = cnt;
endmodule

// File: tb/tb_copro_result_tx.sv
// tb_copro_result_tx: scoreboard bench with a queue-based reference model for copro_result_tx
module tb_copro_result_tx;
  typedef struct {
    logic [31:0] d;
    logic [1:0]  h;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
  } ent_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        fire = 0, alu_v = 0, we_v = 0;
  logic [31:0] data_v = 0;
  logic [1:0]  hart_v = 0;
  logic [3:0]  id_v = 0;
  logic [4:0]  rd_v = 0;
  logic        issue_ready, overflow;
  logic [2:0]  occupancy;
  int          total = 0, bad = 0;
  ent_t        mq[$];
  int          m_rsv = 0;
  bit          m_ovf = 0;
  int          inflight = 0;
  always #5 clk = ~clk;
  copro_result_tx_if #(.XLEN(32), .hartid_t(logic [1:0]), .id_t(logic [3:0])) rif ();
  copro_result_tx #(.XLEN(32), .DEPTH(4), .hartid_t(logic [1:0]), .id_t(logic [3:0])) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .issue_fire_i  (fire),
    .issue_ready_o (issue_ready),
    .alu_valid_i   (alu_v),
    .alu_result_i  (data_v),
    .alu_hartid_i  (hart_v),
    .alu_id_i      (id_v),
    .alu_rd_i      (rd_v),
    .alu_we_i      (we_v),
    .result        (rif.master),
    .occupancy_o   (occupancy),
    .overflow_o    (overflow)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    bit pop, acc;
    if (!rst_n) begin
      mq.delete();
      m_rsv = 0;
      m_ovf = 0;
      chk("rst_valid", rif.valid, 0);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_occ", occupancy, 0);
      chk("rst_ovf", overflow, 0);
    end else begin
      chk("valid", rif.valid, mq.size() != 0);
      chk("occupancy", occupancy, mq.size());
      chk("issue_ready", issue_ready, (mq.size() + m_rsv) < 4);
      chk("overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
        chk("data", rif.data, mq[0].d);
        chk("hartid", rif.hartid, mq[0].h);
        chk("id", rif.id, mq[0].id);
        chk("rd", rif.rd, mq[0].rd);
        chk("we", rif.we, mq[0].we);
      end else begin
        chk("idle_fields", {rif.data, rif.hartid, rif.id, rif.rd, rif.we}, 0);
      end
      pop = mq.size() != 0 && rif.ready;
      acc = alu_v && (mq.size() < 4 || pop);
      if (alu_v && (m_rsv == 0 || (mq.size() == 4 && !pop))) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{data_v, hart_v, id_v, rd_v, we_v});
      if (fire && !alu_v) m_rsv++;
      else if (!fire && alu_v && m_rsv > 0) m_rsv--;
    end
  end
  task automatic step(input logic f, input logic v, input logic r, input logic [31:0] d,
                      input logic [3:0] id, input logic [4:0] rd, input logic we);
    @(posedge clk);
    #1;
    fire = f; alu_v = v; rif.ready = r;
    data_v = d; hart_v = 2'($urandom); id_v = id; rd_v = rd; we_v = we;
  endtask
  task automatic fill(input int base);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, $urandom, 4'(base + i), 5'($urandom), 1'($urandom));
  endtask
  initial begin
    rif.ready = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 32'h5, 4'd3, 5'd10, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    fill(0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
    fill(0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'hdead_beef, 4'd4, 5'd7, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
    fill(8);
    step(0, 1, 0, 32'hbad0_bad0, 4'd15, 5'd31, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_valid", rif.valid, 0);
    chk("async_occ", occupancy, 0);
    chk("async_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    inflight = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rif.ready = $urandom_range(0, 3) != 0;
      alu_v = inflight > 0 && $urandom_range(0, 1) == 1;
      fire = issue_ready && $urandom_range(0, 1) == 1;
      data_v = $urandom; hart_v = 2'($urandom); id_v = 4'($urandom);
      rd_v = 5'($urandom); we_v = 1'($urandom);
      inflight = inflight + int'(fire) - int'(alu_v);
    end
    for (int c = 0; c < 50 && (inflight > 0 || occupancy != 0); c++) begin
      @(posedge clk);
      #1;
      fire = 0;
      rif.ready = 1;
      alu_v = inflight > 0;
      data_v = $urandom; id_v = 4'($urandom);
      inflight = inflight - int'(alu_v);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drained_occ", occupancy, 0);
    chk("drained_ready", issue_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
